elevator_scan_controller: RTL

Parametrised next-generation elevator car controller for the elevator design. It latches any number of outstanding floor requests in a pending bitmask instead of tracking a single requested floor. It serves them in SCAN order, continuing in the current direction while requests remain ahead and reversing otherwise. It times floor-to-floor travel and door dwell internally and drives direction, door and position outputs directly to the car/display logic.

---
 rtl/elevator_pkg.sv | 15 +
 rtl/elevator_req_mask.sv | 53 +++++
 rtl/elevator_scan_controller.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/elevator_pkg.sv
// Shared types and default parameters for the SCAN elevator controller.
package elevator_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MOVE_UP   = 2'd1,
        MOVE_DOWN = 2'd2,
        DOOR_OPEN = 2'd3
    } elev_state_t;

    localparam int DEF_NUM_FLOORS    = 16;
    localparam int DEF_TRAVEL_CYCLES = 4;
    localparam int DEF_DOOR_CYCLES   = 8;

endpackage

// File: rtl/elevator_req_mask.sv
// Pending-request bitmask with the floor-relative reductions the SCAN decision needs.
module elevator_req_mask #(
    parameter int NUM_FLOORS = 16,
    parameter int FLOOR_W    = $clog2(NUM_FLOORS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  set_en,
    input  logic [FLOOR_W-1:0]    set_idx,
    input  logic                  clr_en,
    input  logic [FLOOR_W-1:0]    clr_idx,
    input  logic [FLOOR_W-1:0]    cur_floor,
    output logic [NUM_FLOORS-1:0] pending,
    output logic                  any_above,
    output logic                  any_below,
    output logic                  here,
    output logic                  next_up,
    output logic                  next_down
);

    logic [NUM_FLOORS-1:0] set_vec;
    logic [NUM_FLOORS-1:0] clr_vec;

    // next_up/next_down expose the bit of the floor the car is about to step onto.
    always_comb begin
        set_vec   = '0;
        clr_vec   = '0;
        any_above = 1'b0;
        any_below = 1'b0;
        here      = 1'b0;
        next_up   = 1'b0;
        next_down = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (set_en && set_idx == FLOOR_W'(i)) set_vec[i] = 1'b1;
            if (clr_en && clr_idx == FLOOR_W'(i)) clr_vec[i] = 1'b1;
            if (FLOOR_W'(i) > cur_floor) any_above = any_above | pending[i];
            if (FLOOR_W'(i) < cur_floor) any_below = any_below | pending[i];
            if (FLOOR_W'(i) == cur_floor) here = pending[i];
            if (i > 0 && FLOOR_W'(i - 1) == cur_floor) next_up = pending[i];
            if (i < NUM_FLOORS - 1 && FLOOR_W'(i + 1) == cur_floor) next_down = pending[i];
        end
    end

    // Clear is only raised when the car stops at that floor, so it wins a same-edge set.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending <= '0;
        end else begin
            pending <= (pending | set_vec) & ~clr_vec;
        end
    end

endmodule

// File: rtl/elevator_scan_controller.sv
// SCAN-order elevator car controller: latches floor requests, times travel and door dwell.
module elevator_scan_controller
    import elevator_pkg::*;
#(
    parameter  int NUM_FLOORS    = DEF_NUM_FLOORS,
    parameter  int TRAVEL_CYCLES = DEF_TRAVEL_CYCLES,
    parameter  int DOOR_CYCLES   = DEF_DOOR_CYCLES,
    localparam int FLOOR_W       = $clog2(NUM_FLOORS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    input  logic [FLOOR_W-1:0]    req_floor,
    output logic                  req_err,
    output logic [FLOOR_W-1:0]    current_floor,
    output logic                  moving_up,
    output logic                  moving_down,
    output logic                  door_open,
    output logic                  idle,
    output logic [NUM_FLOORS-1:0] pending,
    output logic [1:0]            state_dbg
);

    localparam int TW = $clog2(TRAVEL_CYCLES + 1);
    localparam int DW = $clog2(DOOR_CYCLES + 1);
    localparam logic [TW-1:0]      TRAVEL_LAST = TW'(TRAVEL_CYCLES - 1);
    localparam logic [DW-1:0]      DOOR_LOAD   = DW'(DOOR_CYCLES);
    localparam logic [FLOOR_W-1:0] TOP_FLOOR   = FLOOR_W'(NUM_FLOORS - 1);

    elev_state_t        state, dec_state;
    logic               dir_up, dec_dir;
    logic [TW-1:0]      travel_cnt;
    logic [DW-1:0]      door_cnt;
    logic               in_range, req_ok, at_door_floor, reload, set_en;
    logic               step_now, door_done, decide;
    logic               clr_en;
    logic [FLOOR_W-1:0] clr_idx;
    logic               any_above, any_below, here, next_up, next_down;

    assign in_range      = 32'(req_floor) < 32'(NUM_FLOORS);
    assign req_ok        = req_valid && in_range;
    assign at_door_floor = (state == DOOR_OPEN) && (req_floor == current_floor);
    assign reload        = req_ok && at_door_floor;
    assign set_en        = req_ok && !at_door_floor;
    assign step_now      = (state == MOVE_UP || state == MOVE_DOWN) && travel_cnt == TRAVEL_LAST;
    assign door_done     = (state == DOOR_OPEN) && door_cnt == DW'(1) && !reload;
    assign decide        = (state == IDLE) || door_done;

    elevator_req_mask #(.NUM_FLOORS(NUM_FLOORS), .FLOOR_W(FLOOR_W)) u_mask (
        .clk       (clk),
        .reset     (reset),
        .set_en    (set_en),
        .set_idx   (req_floor),
        .clr_en    (clr_en),
        .clr_idx   (clr_idx),
        .cur_floor (current_floor),
        .pending   (pending),
        .any_above (any_above),
        .any_below (any_below),
        .here      (here),
        .next_up   (next_up),
        .next_down (next_down)
    );

    // SCAN priority: serve here, keep going up, else go down, else turn up.
    always_comb begin
        dec_state = IDLE;
        dec_dir   = dir_up;
        if (here)                    dec_state = DOOR_OPEN;
        else if (dir_up && any_above) dec_state = MOVE_UP;
        else if (any_below) begin
            dec_state = MOVE_DOWN;
            dec_dir   = 1'b0;
        end else if (any_above) begin
            dec_state = MOVE_UP;
            dec_dir   = 1'b1;
        end
    end

    always_comb begin
        clr_en  = 1'b0;
        clr_idx = current_floor;
        if (decide) begin
            clr_en = here;
        end else if (step_now && state == MOVE_UP && next_up) begin
            clr_en  = 1'b1;
            clr_idx = current_floor + FLOOR_W'(1);
        end else if (step_now && state == MOVE_DOWN && next_down) begin
            clr_en  = 1'b1;
            clr_idx = current_floor - FLOOR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            dir_up        <= 1'b1;
            current_floor <= '0;
            travel_cnt    <= '0;
            door_cnt      <= '0;
            req_err       <= 1'b0;
        end else begin
            req_err <= req_valid && !in_range;
            if (decide) begin
                state      <= dec_state;
                dir_up     <= dec_dir;
                travel_cnt <= '0;
                door_cnt   <= (dec_state == DOOR_OPEN) ? DOOR_LOAD : '0;
            end else begin
                case (state)
                    MOVE_UP, MOVE_DOWN: begin
                        if (step_now) begin
                            travel_cnt    <= '0;
                            current_floor <= (state == MOVE_UP) ? current_floor + FLOOR_W'(1)
                                                                : current_floor - FLOOR_W'(1);
                            if (clr_en) begin
                                state    <= DOOR_OPEN;
                                door_cnt <= DOOR_LOAD;
                            end
                        end else begin
                            travel_cnt <= travel_cnt + TW'(1);
                        end
                    end
                    DOOR_OPEN: door_cnt <= reload ? DOOR_LOAD : door_cnt - DW'(1);
                    default: ;
                endcase
            end
        end
    end

    assign moving_up   = (state == MOVE_UP);
    assign moving_down = (state == MOVE_DOWN);
    assign door_open   = (state == DOOR_OPEN);
    assign idle        = (state == IDLE) && (pending == '0);
    assign state_dbg   = state;

    step_in_range_a: assert property (@(posedge clk) disable iff (!reset)
        !(step_now && ((state == MOVE_UP && current_floor == TOP_FLOOR) ||
                       (state == MOVE_DOWN && current_floor == '0))));

endmodule
